// File: rtl/pim_host_pkg.sv
// Shared types and constants for the PIM host issuer: job kinds, FSM states,
// error codes and the wait-timer width helper.
package pim_host_pkg;

  typedef enum logic [1:0] {
    JOB_CMD     = 2'd0,
    JOB_MP_LOAD = 2'd1,
    JOB_MP_RUN  = 2'd2,
    JOB_FENCE   = 2'd3
  } job_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_EXEC,
    S_WAIT_IDLE,
    S_FENCE,
    S_DONE,
    S_ERR
  } issuer_state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_CMD_TIMEOUT  = 2'd1,
    ERR_ACK_TIMEOUT  = 2'd2,
    ERR_EXEC_TIMEOUT = 2'd3
  } err_code_e;

  // Sequencer start latency before pim_system_idle is meaningful after an execute.
  localparam int IDLE_SETTLE_CYCLES = 2;

  function automatic int timer_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/pim_wait_timer.sv
// Clearable wait counter; o_expired flags the cycle whose unmet condition
// would complete TIMEOUT_CYCLES waiting cycles. TIMEOUT_CYCLES=0 never expires.
module pim_wait_timer
  import pim_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int W = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + ONE;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign o_expired = 1'b0;
    end else begin : g_timeout
      localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
      assign o_expired = i_inc && (r_count == LAST);
    end
  endgenerate

endmodule

// File: rtl/pim_host_issuer.sv
// CPU-side initiator: takes host jobs and sequences them onto the PIM command,
// microprogram-load and execute channels, with a per-phase timeout.
module pim_host_issuer
  import pim_host_pkg::*;
#(
  parameter int CMD_SIZE_BITS       = 64,
  parameter int MICROPROG_LEN_WORDS = 4,
  parameter int TIMEOUT_CYCLES      = 1024,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         job_valid,
  output logic                                         job_ready,
  input  logic [1:0]                                   job_kind,
  input  logic [CMD_SIZE_BITS*MICROPROG_LEN_WORDS-1:0] job_data,
  output logic                                         cpu_cmd_valid,
  output logic [CMD_SIZE_BITS-1:0]                     cpu_cmd_data,
  input  logic                                         cpu_cmd_ready,
  output logic                                         cpu_microprog_valid,
  output logic [CMD_SIZE_BITS*MICROPROG_LEN_WORDS-1:0] cpu_microprog_data,
  input  logic                                         cpu_microprog_ack,
  output logic                                         cpu_execute_seq_valid,
  input  logic                                         cpu_execute_seq_ready,
  input  logic                                         pim_system_idle,
  output logic                                         busy,
  output logic                                         job_done,
  output logic                                         job_err,
  output logic [1:0]                                   err_code,
  output logic [CNT_WIDTH-1:0]                         jobs_ok,
  output logic [CNT_WIDTH-1:0]                         jobs_err
);

  localparam int MP_BITS = CMD_SIZE_BITS * MICROPROG_LEN_WORDS;
  localparam logic [1:0] SETTLE_LAST = 2'(IDLE_SETTLE_CYCLES);

  issuer_state_e        r_state, w_state_next;
  job_kind_e            r_kind;
  err_code_e            r_err_code;
  logic [MP_BITS-1:0]   r_payload;
  logic [1:0]           r_settle;
  logic [CNT_WIDTH-1:0] r_jobs_ok, r_jobs_err;
  logic                 w_accept, w_settled, w_wait_inc, w_expired, w_state_change;

  assign w_accept       = job_valid && job_ready;
  assign w_settled      = (r_settle == SETTLE_LAST);
  assign w_state_change = (w_state_next != r_state);

  pim_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_state_change),
    .i_inc     (w_wait_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // A handshake in the same cycle as expiry always wins: it is tested first.
  always_comb begin
    w_state_next = r_state;
    w_wait_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (job_kind_e'(job_kind))
            JOB_CMD:                 w_state_next = S_CMD;
            JOB_MP_LOAD, JOB_MP_RUN: w_state_next = S_LOAD;
            default:                 w_state_next = S_FENCE;
          endcase
        end
      end
      S_CMD: begin
        w_wait_inc = !cpu_cmd_ready;
        if (cpu_cmd_ready)  w_state_next = S_DONE;
        else if (w_expired) w_state_next = S_ERR;
      end
      S_LOAD: begin
        w_wait_inc = !cpu_microprog_ack;
        if (cpu_microprog_ack) w_state_next = (r_kind == JOB_MP_RUN) ? S_EXEC : S_DONE;
        else if (w_expired)    w_state_next = S_ERR;
      end
      S_EXEC: begin
        w_wait_inc = !cpu_execute_seq_ready;
        if (cpu_execute_seq_ready) w_state_next = S_WAIT_IDLE;
        else if (w_expired)        w_state_next = S_ERR;
      end
      S_WAIT_IDLE: begin
        w_wait_inc = w_settled && !pim_system_idle;
        if (w_settled && pim_system_idle) w_state_next = S_DONE;
        else if (w_expired)               w_state_next = S_ERR;
      end
      S_FENCE: begin
        w_wait_inc = !pim_system_idle;
        if (pim_system_idle) w_state_next = S_DONE;
        else if (w_expired)  w_state_next = S_ERR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    job_ready             = (r_state == S_IDLE);
    busy                  = (r_state != S_IDLE);
    cpu_cmd_valid         = (r_state == S_CMD);
    cpu_microprog_valid   = (r_state == S_LOAD);
    cpu_execute_seq_valid = (r_state == S_EXEC);
    job_done              = (r_state == S_DONE);
    job_err               = (r_state == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind     <= JOB_CMD;
      r_payload  <= '0;
      r_settle   <= '0;
      r_err_code <= ERR_NONE;
      r_jobs_ok  <= '0;
      r_jobs_err <= '0;
    end else begin
      if (w_accept) begin
        r_kind    <= job_kind_e'(job_kind);
        r_payload <= job_data;
      end
      if (w_state_change)                              r_settle <= '0;
      else if (r_state == S_WAIT_IDLE && !w_settled)   r_settle <= r_settle + 2'd1;
      if (w_state_next == S_ERR && r_state != S_ERR) begin
        case (r_state)
          S_CMD:   r_err_code <= ERR_CMD_TIMEOUT;
          S_LOAD:  r_err_code <= ERR_ACK_TIMEOUT;
          default: r_err_code <= ERR_EXEC_TIMEOUT;
        endcase
      end
      if (r_state == S_DONE) r_jobs_ok  <= r_jobs_ok + 1'b1;
      if (r_state == S_ERR)  r_jobs_err <= r_jobs_err + 1'b1;
    end
  end

  assign cpu_cmd_data       = r_payload[CMD_SIZE_BITS-1:0];
  assign cpu_microprog_data = r_payload;
  assign err_code           = r_err_code;
  assign jobs_ok            = r_jobs_ok;
  assign jobs_err           = r_jobs_err;

endmodule

// File: tb/tb_pim_host_issuer.sv
// Scoreboard bench for pim_host_issuer: directed jobs push expected channel
// events; a negedge monitor pops and compares them as the DUTs emit them.
module tb_pim_host_issuer;

  localparam int CW  = 64;
  localparam int MPB = 256;
  localparam int EV_CMD = 1, EV_MP = 2, EV_EXEC = 3, EV_DONE = 4, EV_ERR = 5;

  typedef struct {
    int             ev;
    logic [MPB-1:0] data;
  } ev_t;

  logic           clk, rst_n;
  logic           job_valid, job_ready;
  logic [1:0]     job_kind;
  logic [MPB-1:0] job_data;
  logic           cpu_cmd_valid, cpu_cmd_ready;
  logic [CW-1:0]  cpu_cmd_data;
  logic           cpu_microprog_valid, cpu_microprog_ack, ack_en;
  logic [MPB-1:0] cpu_microprog_data;
  logic           cpu_execute_seq_valid, cpu_execute_seq_ready;
  logic           pim_system_idle;
  logic           busy, job_done, job_err;
  logic [1:0]     err_code;
  logic [15:0]    jobs_ok, jobs_err;

  logic           t_job_valid, t_job_ready;
  logic [1:0]     t_job_kind;
  logic           t_cmd_valid, t_mp_valid, t_exec_valid;
  logic [CW-1:0]  t_cmd_data;
  logic [MPB-1:0] t_mp_data;
  logic           t_busy, t_job_done, t_job_err;
  logic [1:0]     t_err_code;
  logic [15:0]    t_jobs_ok, t_jobs_err;

  int  checks, errors, mp_writes;
  ev_t sb[$];

  // Level-triggered FIFO model: acks in the same cycle as valid when enabled.
  assign cpu_microprog_ack = ack_en & cpu_microprog_valid;

  pim_host_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_kind(job_kind), .job_data(job_data),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_data(cpu_cmd_data), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_microprog_valid(cpu_microprog_valid), .cpu_microprog_data(cpu_microprog_data),
    .cpu_microprog_ack(cpu_microprog_ack),
    .cpu_execute_seq_valid(cpu_execute_seq_valid), .cpu_execute_seq_ready(cpu_execute_seq_ready),
    .pim_system_idle(pim_system_idle),
    .busy(busy), .job_done(job_done), .job_err(job_err), .err_code(err_code),
    .jobs_ok(jobs_ok), .jobs_err(jobs_err)
  );

  pim_host_issuer #(.TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .job_valid(t_job_valid), .job_ready(t_job_ready), .job_kind(t_job_kind), .job_data('0),
    .cpu_cmd_valid(t_cmd_valid), .cpu_cmd_data(t_cmd_data), .cpu_cmd_ready(1'b0),
    .cpu_microprog_valid(t_mp_valid), .cpu_microprog_data(t_mp_data),
    .cpu_microprog_ack(1'b0),
    .cpu_execute_seq_valid(t_exec_valid), .cpu_execute_seq_ready(1'b0),
    .pim_system_idle(1'b0),
    .busy(t_busy), .job_done(t_job_done), .job_err(t_job_err), .err_code(t_err_code),
    .jobs_ok(t_jobs_ok), .jobs_err(t_jobs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [MPB-1:0] act, input logic [MPB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input int ev, input logic [MPB-1:0] d);
    ev_t e;
    e.ev   = ev;
    e.data = d;
    sb.push_back(e);
  endfunction

  task automatic got(input int ev, input logic [MPB-1:0] d);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %0d data %0h, expected no event", ev, d);
    end else begin
      e = sb.pop_front();
      if (e.ev != ev || e.data !== d) begin
        errors++;
        $display("FAIL sb_event: got event %0d data %0h expected event %0d data %0h",
                 ev, d, e.ev, e.data);
      end else begin
        $display("txn event %0d data %0h ok", ev, d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (int'(cpu_cmd_valid) + int'(cpu_microprog_valid) + int'(cpu_execute_seq_valid) > 1) begin
      checks++;
      errors++;
      $display("FAIL channel_overlap: cmd %0b mp %0b exec %0b expected at most one high",
               cpu_cmd_valid, cpu_microprog_valid, cpu_execute_seq_valid);
    end
    if (cpu_cmd_valid && cpu_cmd_ready) got(EV_CMD, MPB'(cpu_cmd_data));
    if (cpu_microprog_valid && cpu_microprog_ack) begin
      mp_writes++;
      got(EV_MP, cpu_microprog_data);
    end
    if (cpu_execute_seq_valid && cpu_execute_seq_ready) got(EV_EXEC, '0);
    if (job_done)   got(EV_DONE, MPB'(err_code));
    if (job_err)    got(EV_ERR, MPB'(err_code));
    if (t_job_done) got(EV_DONE, MPB'(t_err_code));
    if (t_job_err)  got(EV_ERR, MPB'(t_err_code));
  end

  task automatic send_job(input logic [1:0] k, input logic [MPB-1:0] d);
    int g;
    g         = 0;
    job_kind  = k;
    job_data  = d;
    job_valid = 1'b1;
    while (!job_ready && g < 50) begin
      tick();
      g++;
    end
    chk("job_accept_ready", MPB'(job_ready), MPB'(1));
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    logic [MPB-1:0] d_cmd, d_mp, d_run;
    int vcnt, n;
    logic stable, early;

    d_cmd = MPB'(64'hA5A5_0000_0000_0001);
    d_mp  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_0F0F_F0F0_F0F0};
    d_run = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
             64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    checks = 0; errors = 0; mp_writes = 0;
    rst_n = 1'b0; job_valid = 1'b0; job_kind = 2'd0; job_data = '0;
    cpu_cmd_ready = 1'b0; ack_en = 1'b0; cpu_execute_seq_ready = 1'b0;
    pim_system_idle = 1'b1; t_job_valid = 1'b0; t_job_kind = 2'd0;

    #12;
    chk("rst_busy", MPB'(busy), '0);
    chk("rst_cmd_valid", MPB'(cpu_cmd_valid), '0);
    chk("rst_mp_valid", MPB'(cpu_microprog_valid), '0);
    chk("rst_exec_valid", MPB'(cpu_execute_seq_valid), '0);
    chk("rst_done_err", MPB'({job_done, job_err}), '0);
    chk("rst_err_code", MPB'(err_code), '0);
    chk("rst_counters", MPB'({jobs_ok, jobs_err}), '0);
    tick();
    rst_n = 1'b1;
    tick();

    // CMD: ready low for 3 valid cycles, high on the 4th.
    push(EV_CMD, d_cmd);
    push(EV_DONE, '0);
    send_job(2'd0, d_cmd);
    vcnt = 0; stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cpu_cmd_valid) vcnt++;
      if (cpu_cmd_data !== d_cmd[CW-1:0]) stable = 1'b0;
      if (i == 3) cpu_cmd_ready = 1'b1;
      tick();
    end
    cpu_cmd_ready = 1'b0;
    chk("cmd_valid_cycles", MPB'(vcnt), MPB'(4));
    chk("cmd_data_stable", MPB'(stable), MPB'(1));
    chk("cmd_valid_drop", MPB'(cpu_cmd_valid), '0);
    chk("cmd_done_pulse", MPB'(job_done), MPB'(1));
    tick();
    chk("cmd_jobs_ok", MPB'(jobs_ok), MPB'(1));

    // MP_LOAD acked on the first valid cycle.
    ack_en = 1'b1;
    push(EV_MP, d_mp);
    push(EV_DONE, '0);
    send_job(2'd1, d_mp);
    chk("load_valid_first", MPB'(cpu_microprog_valid), MPB'(1));
    tick();
    ack_en = 1'b0;
    chk("load_valid_drop", MPB'(cpu_microprog_valid), '0);
    chk("load_done_pulse", MPB'(job_done), MPB'(1));
    chk("load_one_write", MPB'(mp_writes), MPB'(1));
    chk("load_err_code", MPB'(err_code), '0);
    tick();

    // MP_RUN: load, execute after 2 cycles, idle low for 10 cycles.
    ack_en = 1'b1;
    pim_system_idle = 1'b0;
    push(EV_MP, d_run);
    push(EV_EXEC, '0);
    push(EV_DONE, '0);
    send_job(2'd2, d_run);
    tick();
    ack_en = 1'b0;
    chk("run_exec_valid", MPB'(cpu_execute_seq_valid), MPB'(1));
    tick();
    cpu_execute_seq_ready = 1'b1;
    tick();
    cpu_execute_seq_ready = 1'b0;
    chk("run_exec_drop", MPB'(cpu_execute_seq_valid), '0);
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (job_done || !busy) early = 1'b1;
      tick();
    end
    chk("run_wait_idle_held", MPB'(early), '0);
    pim_system_idle = 1'b1;
    n = 0;
    while (!job_done && n < 10) begin
      tick();
      n++;
    end
    chk("run_done_after_idle", MPB'(n), MPB'(1));
    tick();

    // FENCE with the system already idle.
    push(EV_DONE, '0);
    send_job(2'd3, '0);
    chk("fence_no_done_yet", MPB'(job_done), '0);
    tick();
    chk("fence_done_pulse", MPB'(job_done), MPB'(1));
    tick();
    chk("fence_jobs_ok", MPB'(jobs_ok), MPB'(4));

    // Reset in the middle of a never-acked LOAD.
    send_job(2'd1, d_mp);
    tick();
    chk("midload_valid", MPB'(cpu_microprog_valid), MPB'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mp_valid", MPB'(cpu_microprog_valid), '0);
    chk("async_rst_busy", MPB'(busy), '0);
    chk("async_rst_jobs_ok", MPB'(jobs_ok), '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(EV_DONE, '0);
    send_job(2'd3, '0);
    tick();
    tick();
    chk("post_rst_jobs_ok", MPB'(jobs_ok), MPB'(1));

    // Timeout instance (TIMEOUT_CYCLES=8): command never accepted.
    push(EV_ERR, MPB'(1));
    t_job_kind  = 2'd0;
    t_job_valid = 1'b1;
    tick();
    t_job_valid = 1'b0;
    vcnt = 0; n = 0;
    while (!t_job_err && n < 20) begin
      if (t_cmd_valid) vcnt++;
      tick();
      n++;
    end
    chk("to_valid_cycles", MPB'(vcnt), MPB'(8));
    chk("to_err_pulse", MPB'(t_job_err), MPB'(1));
    chk("to_err_code", MPB'(t_err_code), MPB'(1));
    chk("to_cmd_valid_off", MPB'(t_cmd_valid), '0);
    tick();
    chk("to_jobs_err", MPB'(t_jobs_err), MPB'(1));
    chk("to_job_ready", MPB'(t_job_ready), MPB'(1));
    chk("to_err_sticky", MPB'(t_err_code), MPB'(1));

    repeat (3) tick();
    chk("sb_empty", MPB'(sb.size()), '0);
    chk("total_mp_writes", MPB'(mp_writes), MPB'(2));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
